// File: rtl/lenet_frame_sequencer.sv
// Sequences one Mini_LeNet inference: streams a 28x28 frame from the pixel buffer,
// appends pad beats, waits out the network latency and reports the predicted class.
module lenet_frame_sequencer #(
    parameter int N_PIX       = 784,
    parameter int PAD_BEATS   = 1,
    parameter int RES_LATENCY = 4096,
    parameter int ADDR_W      = 10,
    parameter int LAT_W       = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        cnn_data,
    output logic              cnn_data_valid,
    input  logic [3:0]        cnn_pred,
    output logic [3:0]        result,
    output logic              result_valid
);

    localparam int PAD_W = (PAD_BEATS > 1) ? $clog2(PAD_BEATS) : 1;
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(N_PIX - 1);
    localparam logic [PAD_W-1:0]  PAD_LAST = PAD_W'((PAD_BEATS > 0) ? PAD_BEATS - 1 : 0);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RES_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_PAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pix_cnt, pix_cnt_next;
    logic [PAD_W-1:0]  pad_cnt, pad_cnt_next;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_next;
    logic              result_load;
    logic              rd_vld_q;
    logic              pad_vld_q;

    always_comb begin
        state_next   = state;
        pix_cnt_next = pix_cnt;
        pad_cnt_next = pad_cnt;
        lat_cnt_next = lat_cnt;
        rd_en        = 1'b0;
        result_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_FEED;
                    pix_cnt_next = '0;
                end
            end
            S_FEED: begin
                // hold lends the buffer port to the camera writer: no read, counter frozen
                if (!hold) begin
                    rd_en = 1'b1;
                    if (pix_cnt == PIX_LAST) begin
                        pix_cnt_next = '0;
                        pad_cnt_next = '0;
                        lat_cnt_next = '0;
                        state_next   = (PAD_BEATS == 0) ? S_WAIT : S_PAD;
                    end else begin
                        pix_cnt_next = pix_cnt + 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (pad_cnt == PAD_LAST) begin
                    state_next   = S_WAIT;
                    lat_cnt_next = '0;
                end else begin
                    pad_cnt_next = pad_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_next  = S_DONE;
                    result_load = 1'b1;
                end else begin
                    lat_cnt_next = lat_cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pix_cnt   <= '0;
            pad_cnt   <= '0;
            lat_cnt   <= '0;
            rd_vld_q  <= 1'b0;
            pad_vld_q <= 1'b0;
            result    <= '0;
        end else begin
            state     <= state_next;
            pix_cnt   <= pix_cnt_next;
            pad_cnt   <= pad_cnt_next;
            lat_cnt   <= lat_cnt_next;
            rd_vld_q  <= rd_en;
            pad_vld_q <= (state == S_PAD);
            if (result_load) begin
                result <= cnn_pred;
            end
        end
    end

    // Stream to Mini_LeNet has no back-pressure: every cycle with cnn_data_valid=1
    // is one accepted beat; rd_data arrives the cycle after rd_en and is passed straight on.
    assign cnn_data_valid = rd_vld_q | pad_vld_q;
    assign cnn_data       = rd_vld_q ? rd_data : 8'd0;
    assign rd_addr        = pix_cnt;
    assign busy           = (state != S_IDLE);
    assign result_valid   = (state == S_DONE);

endmodule

// File: tb/tb_lenet_frame_sequencer.sv
// Bench for lenet_frame_sequencer: a frame-level reference model predicts reads, beats and
// result timing every cycle; directed runs pin reset, hold, ignored starts and result holding.
module tb_lenet_frame_sequencer;

    localparam int N_PIX       = 784;
    localparam int PAD_BEATS   = 1;
    localparam int RES_LATENCY = 4096;
    localparam int ADDR_W      = 10;
    localparam int LAT_W       = 13;
    localparam int FULL_RUN    = N_PIX + PAD_BEATS + RES_LATENCY + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = 8'd0;
    logic [7:0]        cnn_data;
    logic              cnn_data_valid;
    logic [3:0]        cnn_pred = 4'd0;
    logic [3:0]        result;
    logic              result_valid;

    lenet_frame_sequencer #(
        .N_PIX(N_PIX), .PAD_BEATS(PAD_BEATS), .RES_LATENCY(RES_LATENCY),
        .ADDR_W(ADDR_W), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .cnn_data(cnn_data), .cnn_data_valid(cnn_data_valid), .cnn_pred(cnn_pred),
        .result(result), .result_valid(result_valid)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pixel buffer with one-cycle read latency
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // scoreboard: frame-level model of one inference
    logic [7:0] exp_q[$];
    bit         m_active = 1'b0;
    int         m_reads = 0;
    int         m_pads = 0;
    bit         m_last_issued = 1'b0;
    int         m_done_cyc = 0;
    bit         m_exp_v = 1'b0;
    int         m_beats = 0;
    logic [3:0] m_result = 4'd0;

    always @(negedge clk) begin : compare
        bit e_rd;
        bit e_done;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_valid", cnn_data_valid, 0);
            chk("rst_data", cnn_data, 0);
            chk("rst_result_valid", result_valid, 0);
            chk("rst_result", result, 0);
            m_active      = 1'b0;
            m_last_issued = 1'b0;
            m_exp_v       = 1'b0;
            m_result      = 4'd0;
            exp_q.delete();
        end else begin
            e_rd = m_active && (m_reads < N_PIX) && !hold;
            chk("busy", busy, m_active);
            chk("rd_en", rd_en, e_rd);
            if (e_rd) chk("rd_addr", rd_addr, m_reads);
            chk("cnn_data_valid", cnn_data_valid, m_exp_v);
            if (cnn_data_valid && m_exp_v) begin
                if (exp_q.size() == 0) chk("beat_overrun", 1, 0);
                else chk("cnn_data", cnn_data, exp_q.pop_front());
                m_beats++;
            end
            e_done = m_active && m_last_issued && (cyc == m_done_cyc);
            chk("result_valid", result_valid, e_done);
            chk("result", result, m_result);
            if (e_done) begin
                chk("beats_left", exp_q.size(), 0);
                chk("beat_count", m_beats, 785);
            end

            m_exp_v = 1'b0;
            if (m_active) begin
                if (e_rd) begin
                    m_reads++;
                    m_exp_v = 1'b1;
                    if (m_reads == N_PIX && PAD_BEATS == 0) begin
                        m_last_issued = 1'b1;
                        m_done_cyc    = cyc + RES_LATENCY + 1;
                    end
                end else if (m_reads == N_PIX && m_pads > 0) begin
                    m_pads--;
                    m_exp_v = 1'b1;
                    if (m_pads == 0) begin
                        m_last_issued = 1'b1;
                        m_done_cyc    = cyc + RES_LATENCY + 1;
                    end
                end
                if (m_last_issued && cyc == m_done_cyc - 1) m_result = cnn_pred;
                if (e_done) m_active = 1'b0;
            end else if (start) begin
                m_active      = 1'b1;
                m_reads       = 0;
                m_pads        = PAD_BEATS;
                m_last_issued = 1'b0;
                m_beats       = 0;
                exp_q.delete();
                for (int p = 0; p < N_PIX; p++) exp_q.push_back(mem[p]);
                for (int p = 0; p < PAD_BEATS; p++) exp_q.push_back(8'd0);
            end
        end
    end

    // driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // hmode: 0 no hold, 1 directed hold pattern, 2 random hold and random cnn_pred
    task automatic run(input int hmode, input bit pokes, output int done_off);
        int off;
        bit seen;
        start    = 1'b1;
        hold     = (hmode == 1);
        off      = 0;
        seen     = 1'b0;
        done_off = -1;
        while (!seen && off < 8000) begin
            tick;
            off++;
            start = pokes && (off == 50 || off == 2000 || off == FULL_RUN);
            case (hmode)
                1: hold = (off >= 101 && off <= 103) || (off == 787);
                2: begin
                    hold     = ($urandom_range(0, 9) == 0);
                    cnn_pred = 4'($urandom_range(0, 15));
                end
                default: hold = 1'b0;
            endcase
            if (result_valid) begin
                seen     = 1'b1;
                done_off = off;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        tick;
        start = 1'b0;
        hold  = 1'b0;
        chk("busy_after_done", busy, 0);
    endtask

    initial begin : driver
        int d;
        for (int a = 0; a < (1<<ADDR_W); a++) mem[a] = 8'(a);
        repeat (3) tick;
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        rst_n = 1'b1;
        tick;

        // incrementing frame, no hold
        cnn_pred = 4'd5;
        run(0, 0, d);
        chk("t1_done_offset", d, 4882);
        chk("t1_result", result, 5);
        repeat (3) tick;

        // hold 3 cycles at pixel 100 and 1 cycle at pixel 783
        run(1, 0, d);
        chk("t3_done_offset", d, 4886);
        repeat (2) tick;

        // start pokes during FEED, WAIT and DONE are ignored
        run(0, 1, d);
        chk("t4_done_offset", d, 4882);
        repeat (5) tick;
        chk("t4_idle_busy", busy, 0);
        run(0, 0, d);
        chk("t4_fresh_done_offset", d, 4882);

        // reset at pixel 400
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (400) tick;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_valid", cnn_data_valid, 0);
        chk("t5_result", result, 0);
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        run(0, 0, d);
        chk("t5_done_offset", d, 4882);

        // result latches 9 and holds while cnn_pred moves to 2
        cnn_pred = 4'd9;
        run(0, 0, d);
        cnn_pred = 4'd2;
        chk("t6_result_9", result, 9);
        repeat (20) tick;
        chk("t6_result_hold", result, 9);
        run(0, 0, d);
        chk("t6_result_2", result, 2);

        // random frames with random hold and prediction
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < N_PIX; a++) mem[a] = 8'($urandom_range(0, 255));
            run(2, 0, d);
            repeat (3) tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
